hex_seg_scanner: RTL and testbench
==================================

# hex_seg_scanner

Time-multiplexed N-digit hexadecimal seven-segment display driver. It replaces the static per-digit decode bank with one shared decoder, a scan prescaler, and a digit-index counter driving a one-hot anode bus. It adds double-buffered tear-free updates, per-digit blinking and optional leading-zero suppression. It sits between the CPU/IO register file and the board's common-anode display pins.

## Interface
- DIGITS, 8: number of digits; legal range 2..16.
- SCAN_DIV, 50000: clock cycles each digit is driven; must be ≥ 2.
- BLINK_DIV, 128: full scan frames per blink half-period; must be ≥ 1.
- ACTIVE_LOW, 1: when 1, `seg_out` and `an_out` are active-low; when 0, active-high.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- load  in  1  one-cycle strobe; captures `hex_in`, `point_in`, `blank_in` and `blink_in` into the shadow registers.
- hex_in  in  4*DIGITS  digit i uses nibble [4i+3:4i]; digit 0 is least significant.
- point_in  in  DIGITS  1 lights the decimal point of digit i.
- blank_in  in  DIGITS  1 forces digit i dark.
- blink_in  in  DIGITS  1 makes digit i blink.
- lz_blank  in  1  live enable for leading-zero suppression; not buffered.
- seg_out  out  8  {p,g,f,e,d,c,b,a} for the currently scanned digit.
- an_out  out  DIGITS  one-hot anode select.
- frame_start  out  1  one-cycle pulse when digit 0 output is presented.
- update_pending  out  1  shadow holds data not yet committed.

## Operation
- **Prescaler** `pre` counts 0..SCAN_DIV-1. At the terminal count (`tick`), index `idx` advances 0..DIGITS-1 and wraps to 0.
- **Frame boundary:** `tick` with `idx==DIGITS-1`.
- **Commit at the boundary:**
  - If `update_pending`, shadow is copied to active and `update_pending` clears.
  - `frame_cnt` increments. When it reaches BLINK_DIV-1 it wraps to 0 and `blink_phase` toggles.
- **Load:**
  - A load sets `update_pending=1` and overwrites the shadow; the last load before a boundary wins.
  - A load on the boundary cycle bypasses to active in that cycle, and `update_pending` remains 0.
- **Per-digit dark condition:** `blank[i]`, or `blink[i] & blink_phase`, or leading zero.
  - Leading zero means `lz_blank`, `i≠0`, nibble i = 0 and all nibbles above i = 0.
  - A dark digit has all 8 segments off, including p.
- **Decode:** standard hex glyphs, internally active-high. 0=0x3F, 1=0x06, 5=0x6D, A=0x77, F=0x71; p = `point[i]`.
- **Polarity:** the result is inverted when ACTIVE_LOW.
- **Anode:** `an_out` asserts bit `idx` only; every digit is scanned even when dark.

## Timing
- **Reset values (asynchronous):**
  - `pre`, `idx`, `frame_cnt`, `blink_phase` = 0.
  - Shadow and active registers = 0.
  - `update_pending` = 0; `frame_start` = 0.
  - `seg_out` and `an_out` all off: all-ones if ACTIVE_LOW, else zero.
- **Registered outputs:** `seg_out`, `an_out` and `frame_start` are registered and reflect the `idx`/active state of the previous cycle.
- **After reset release:**
  - Digit 0 appears 1 cycle after deassertion.
  - No `frame_start` until the first wrap.
- **Scan timing:**
  - Digit dwell = SCAN_DIV cycles; frame = DIGITS*SCAN_DIV cycles.
  - Blink half-period = BLINK_DIV frames.
- **Load latency:** load to display ≤ DIGITS*SCAN_DIV + 1 cycles. Data is never applied mid-frame.
- **Mid-operation reset:** returns everything to reset values; pending data is discarded.
- **Counter widths:**
  - `pre`: $clog2(SCAN_DIV).
  - `idx`: $clog2(DIGITS).
  - `frame_cnt`: $clog2(BLINK_DIV+1).
  - No counter ever exceeds its limit.

## Structure
- **Package `seg_pkg`:**
  - Glyph constants SEG_0..SEG_F.
  - SEG_OFF_ACTIVE_HIGH = 8'h00.
  - Bit-position constants for a..g and p.
  - Function `hex_glyph(nibble)`.
- **Sub-module `hex_seg_decode`:** combinational nibble+point → active-high 8-bit segment pattern.
- **`hex_seg_scanner` itself:** counters, shadow/active buffers, dark logic and polarity.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=4, BLINK_DIV=2, ACTIVE_LOW=1.
- **Reset:** assert `rst_n` low mid-scan → `seg_out`=0xFF and `an_out`=4'hF immediately. After release, `an_out`=4'b1110 after 1 cycle, then 4'b1101 four cycles later.
- **Load mid-frame:** load `hex_in`=16'h12AF at idx 1.
  - Remainder of the frame still shows 0 (0xC0) and `update_pending`=1.
  - After the boundary, digit0=0x8E, digit1=0x88, digit3=0xF9, `update_pending`=0.
- **Leading zero:** `lz_blank`=1, `hex_in`=16'h0050 → digits 3 and 2 show 0xFF, digit1=0x92, digit0=0xC0. With `lz_blank`=0, digit3=0xC0.
- **Blink:** `blink_in`=4'b0001 → digit0 shows 0xFF during frames where `blink_phase`=1. The phase toggles every 32 cycles; other digits are unaffected.
- **Load on boundary:** load coincides with the tick at idx 3 → the new value is shown at the very next digit 0, and `update_pending` never goes high.
- **Point and blank:** `point_in`=4'b0100 with hex 0 → digit2=0x40. Adding `blank_in`=4'b0100 → digit2=0xFF; `frame_start` pulses every 16 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment constants and the hex glyph table.
// Bit order is {p,g,f,e,d,c,b,a}; all patterns here are active-high.
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;
    localparam int SEG_P_BIT = 7;

    localparam seg_t SEG_OFF_ACTIVE_HIGH = 8'h00;

    localparam seg_t SEG_0 = 8'h3F;
    localparam seg_t SEG_1 = 8'h06;
    localparam seg_t SEG_2 = 8'h5B;
    localparam seg_t SEG_3 = 8'h4F;
    localparam seg_t SEG_4 = 8'h66;
    localparam seg_t SEG_5 = 8'h6D;
    localparam seg_t SEG_6 = 8'h7D;
    localparam seg_t SEG_7 = 8'h07;
    localparam seg_t SEG_8 = 8'h7F;
    localparam seg_t SEG_9 = 8'h6F;
    localparam seg_t SEG_A = 8'h77;
    localparam seg_t SEG_B = 8'h7C;
    localparam seg_t SEG_C = 8'h39;
    localparam seg_t SEG_D = 8'h5E;
    localparam seg_t SEG_E = 8'h79;
    localparam seg_t SEG_F = 8'h71;

    // Glyph only; the decimal point bit is always returned clear.
    function automatic seg_t hex_glyph(input logic [3:0] nibble);
        seg_t g;
        unique case (nibble)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            4'hF: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Shared combinational decoder: nibble + point -> active-high segments.
// Ports: nibble_i (4), point_i (1) in; seg_o (8, {p,g,f,e,d,c,b,a}) out.
module hex_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       point_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o            = hex_glyph(nibble_i);
        seg_o[SEG_P_BIT] = point_i;
    end

endmodule

// File: rtl/hex_seg_scanner.sv
// Time-multiplexed N-digit hex seven-segment driver with tear-free
// double buffering, per-digit blink/blank/point and leading-zero blanking.
// In: clk, rst_n, load, hex_in, point_in, blank_in, blink_in, lz_blank.
// Out: seg_out, an_out (registered), frame_start, update_pending.
module hex_seg_scanner
    import seg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 128,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     point_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  lz_blank,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_start,
    output logic                  update_pending
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = $clog2(BLINK_DIV + 1);

    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_DIV - 1);

    // XOR masks applying output polarity; also the "all off" values.
    localparam logic [7:0]        SEG_POL = {8{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{ACTIVE_LOW}};

    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         frm_q, frm_d;
    logic                  phase_q, phase_d;

    logic [4*DIGITS-1:0]   sh_hex_q, ac_hex_q;
    logic [DIGITS-1:0]     sh_pt_q, ac_pt_q;
    logic [DIGITS-1:0]     sh_bk_q, ac_bk_q;
    logic [DIGITS-1:0]     sh_bl_q, ac_bl_q;
    logic                  pend_q, pend_d;

    logic                  bnd_q;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  fs_q;

    logic                  tick;
    logic                  boundary;

    logic [DIGITS-1:0]     dark;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_pt;
    logic                  cur_dark;
    logic [7:0]            dec_seg;
    logic [7:0]            seg_hi;

    assign tick     = (pre_q == PRE_MAX);
    assign boundary = tick && (idx_q == IDX_MAX);

    always_comb begin
        pre_d   = tick ? '0 : pre_q + 1'b1;
        idx_d   = idx_q;
        frm_d   = frm_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        if (boundary) begin
            if (frm_q == FRM_MAX) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
            pend_d = 1'b0;
        end
        // A load on the boundary goes straight to active, so never pends.
        if (load && !boundary) begin
            pend_d = 1'b1;
        end
    end

    // Leading-zero scan runs from the top digit down; digit 0 is exempt.
    always_comb begin
        dark     = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (ac_hex_q[4*i +: 4] == 4'h0);
            dark[i]  = ac_bk_q[i]
                     | (ac_bl_q[i] & phase_q)
                     | (lz_blank & (i != 0) & zero_run);
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_pt   = 1'b0;
        cur_dark = 1'b0;
        an_d     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib  = ac_hex_q[4*i +: 4];
                cur_pt   = ac_pt_q[i];
                cur_dark = dark[i];
                an_d[i]  = 1'b1;
            end
        end
        an_d = an_d ^ AN_POL;
    end

    hex_seg_decode u_decode (
        .nibble_i (cur_nib),
        .point_i  (cur_pt),
        .seg_o    (dec_seg)
    );

    assign seg_hi = cur_dark ? SEG_OFF_ACTIVE_HIGH : dec_seg;
    assign seg_d  = seg_hi ^ SEG_POL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            idx_q    <= '0;
            frm_q    <= '0;
            phase_q  <= 1'b0;
            sh_hex_q <= '0;
            sh_pt_q  <= '0;
            sh_bk_q  <= '0;
            sh_bl_q  <= '0;
            ac_hex_q <= '0;
            ac_pt_q  <= '0;
            ac_bk_q  <= '0;
            ac_bl_q  <= '0;
            pend_q   <= 1'b0;
            bnd_q    <= 1'b0;
            seg_q    <= SEG_POL;
            an_q     <= AN_POL;
            fs_q     <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            if (load) begin
                sh_hex_q <= hex_in;
                sh_pt_q  <= point_in;
                sh_bk_q  <= blank_in;
                sh_bl_q  <= blink_in;
            end
            if (boundary) begin
                if (load) begin
                    ac_hex_q <= hex_in;
                    ac_pt_q  <= point_in;
                    ac_bk_q  <= blank_in;
                    ac_bl_q  <= blink_in;
                end else if (pend_q) begin
                    ac_hex_q <= sh_hex_q;
                    ac_pt_q  <= sh_pt_q;
                    ac_bk_q  <= sh_bk_q;
                    ac_bl_q  <= sh_bl_q;
                end
            end
            // Digit 0 of the new frame reaches the pins two edges after
            // the boundary cycle, so the pulse is delayed to match.
            bnd_q <= boundary;
            fs_q  <= bnd_q;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg_out        = seg_q;
    assign an_out         = an_q;
    assign frame_start    = fs_q;
    assign update_pending = pend_q;

endmodule

// File: tb/tb_hex_seg_scanner.sv
// Scoreboard bench for hex_seg_scanner (4 digits, SCAN_DIV 4, BLINK_DIV 2,
// active-low outputs).
`timescale 1ns/1ps
module tb_hex_seg_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] hex_in;
    logic [3:0]  point_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_in;
    logic        lz_blank;
    logic [7:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_start;
    logic        update_pending;

    always #5 clk = ~clk;

    hex_seg_scanner #(
        .DIGITS     (4),
        .SCAN_DIV   (4),
        .BLINK_DIV  (2),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .hex_in         (hex_in),
        .point_in       (point_in),
        .blank_in       (blank_in),
        .blink_in       (blink_in),
        .lz_blank       (lz_blank),
        .seg_out        (seg_out),
        .an_out         (an_out),
        .frame_start    (frame_start),
        .update_pending (update_pending)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        string      nm;
    } exp_t;

    exp_t sb[$];

    task automatic push_d(int d, logic [7:0] s, string nm);
        exp_t       e;
        logic [3:0] one;
        one   = 4'b0001 << d;
        e.an  = ~one;
        e.seg = s;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Monitor: on each fresh digit presentation matching the queue head,
    // pop it and compare the segment pattern.
    logic [3:0] prev_an = 4'hF;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_an = 4'hF;
        end else begin
            if (an_out != prev_an && sb.size() > 0 && an_out == sb[0].an) begin
                e = sb.pop_front();
                chk(e.nm, {24'h0, seg_out}, {24'h0, e.seg});
            end
            prev_an = an_out;
        end
    end

    task automatic wait_digit(int d);
        logic [3:0] one;
        logic [3:0] tgt;
        logic [3:0] last;
        logic       hit;
        int         n;
        one  = 4'b0001 << d;
        tgt  = ~one;
        last = an_out;
        hit  = 1'b0;
        n    = 0;
        while (!hit && n < 100) begin
            @(negedge clk);
            n++;
            hit  = (an_out == tgt) && (last != tgt);
            last = an_out;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_digit%0d: no presentation in 100 cycles", d);
        end
    endtask

    task automatic wait_q_empty(string nm);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d expectations unmet after 300 cycles",
                     nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_load(logic [15:0] h, logic [3:0] p, logic [3:0] bk,
                           logic [3:0] bl);
        hex_in   = h;
        point_in = p;
        blank_in = bk;
        blink_in = bl;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        int pend_seen;

        rst_n    = 1'b0;
        load     = 1'b0;
        hex_in   = '0;
        point_in = '0;
        blank_in = '0;
        blink_in = '0;
        lz_blank = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", {24'h0, seg_out}, 32'hFF);
        chk("rst_an", {28'h0, an_out}, 32'hF);
        chk("rst_pend", {31'h0, update_pending}, 0);
        chk("rst_fs", {31'h0, frame_start}, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_an_d0", {28'h0, an_out}, 32'hE);
        chk("rel_seg_d0", {24'h0, seg_out}, 32'hC0);
        repeat (4) @(posedge clk);
        #1;
        chk("rel_an_d1", {28'h0, an_out}, 32'hD);

        // First frame_start only after the first wrap (edge 17)
        n = 5;
        while (!frame_start && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_fs_edge", n, 17);
        chk("first_fs_an", {28'h0, an_out}, 32'hE);

        // Mid-scan reset discards pending data
        wait_digit(0);
        do_load(16'hFFFF, 4'h0, 4'h0, 4'h0);
        chk("pend_before_rst", {31'h0, update_pending}, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_seg", {24'h0, seg_out}, 32'hFF);
        chk("midrst_an", {28'h0, an_out}, 32'hF);
        chk("midrst_pend", {31'h0, update_pending}, 0);
        push_d(0, 8'hC0, "midrst_f0d0");
        push_d(1, 8'hC0, "midrst_f0d1");
        push_d(2, 8'hC0, "midrst_f0d2");
        push_d(3, 8'hC0, "midrst_f0d3");
        push_d(0, 8'hC0, "midrst_f1d0_discarded");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_q_empty("midrst_q");

        // Blink: fresh reset gives known phase (frames 2,3 dark)
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_digit(0);
        do_load(16'h0005, 4'h0, 4'h0, 4'b0001);
        push_d(1, 8'hC0, "blink_f0d1");
        push_d(2, 8'hC0, "blink_f0d2");
        push_d(3, 8'hC0, "blink_f0d3");
        for (int f = 1; f <= 4; f++) begin
            push_d(0, (f == 2 || f == 3) ? 8'hFF : 8'h92, "blink_d0");
            push_d(1, 8'hC0, "blink_d1");
            push_d(2, 8'hC0, "blink_d2");
            push_d(3, 8'hC0, "blink_d3");
        end
        wait_q_empty("blink_q");

        // Load mid-frame at idx 1
        wait_digit(1);
        do_load(16'h12AF, 4'h0, 4'h0, 4'h0);
        chk("midload_pend", {31'h0, update_pending}, 1);
        push_d(2, 8'hC0, "midload_old_d2");
        push_d(3, 8'hC0, "midload_old_d3");
        push_d(0, 8'h8E, "midload_d0");
        push_d(1, 8'h88, "midload_d1");
        push_d(2, 8'hA4, "midload_d2");
        push_d(3, 8'hF9, "midload_d3");
        wait_q_empty("midload_q");
        chk("midload_pend_clr", {31'h0, update_pending}, 0);

        // Leading-zero suppression, then live disable
        lz_blank = 1'b1;
        wait_digit(0);
        do_load(16'h0050, 4'h0, 4'h0, 4'h0);
        wait_digit(0);
        push_d(1, 8'h92, "lz_d1");
        push_d(2, 8'hFF, "lz_d2");
        push_d(3, 8'hFF, "lz_d3");
        push_d(0, 8'hC0, "lz_d0");
        wait_q_empty("lz_q");
        lz_blank = 1'b0;
        push_d(1, 8'h92, "nolz_d1");
        push_d(2, 8'hC0, "nolz_d2");
        push_d(3, 8'hC0, "nolz_d3");
        wait_q_empty("nolz_q");

        // Load exactly on the boundary tick (idx 3, pre 3)
        wait_digit(3);
        @(negedge clk);
        @(negedge clk);
        hex_in   = 16'hF5A1;
        point_in = 4'h0;
        blank_in = 4'h0;
        blink_in = 4'h0;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        push_d(0, 8'hF9, "bnd_d0");
        push_d(1, 8'h88, "bnd_d1");
        push_d(2, 8'h92, "bnd_d2");
        push_d(3, 8'h8E, "bnd_d3");
        pend_seen = update_pending ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (update_pending) pend_seen++;
        end
        chk("bnd_no_pending", pend_seen, 0);
        wait_q_empty("bnd_q");

        // Decimal point, then blank overriding it
        wait_digit(0);
        do_load(16'h0000, 4'b0100, 4'h0, 4'h0);
        wait_digit(0);
        push_d(1, 8'hC0, "pt_d1");
        push_d(2, 8'h40, "pt_d2");
        push_d(3, 8'hC0, "pt_d3");
        wait_q_empty("pt_q");
        wait_digit(0);
        do_load(16'h0000, 4'b0100, 4'b0100, 4'h0);
        wait_digit(0);
        push_d(1, 8'hC0, "blank_d1");
        push_d(2, 8'hFF, "blank_d2");
        push_d(3, 8'hC0, "blank_d3");
        wait_q_empty("blank_q");

        // frame_start period
        n = 0;
        while (!frame_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("fs_seen", {31'h0, frame_start}, 1);
        chk("fs_an_d0", {28'h0, an_out}, 32'hE);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!frame_start && m < 40);
        chk("fs_period", m, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
